muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have one clock and reset: reset is synchronous and active-low.
REQ-002 Parameter WIDTH, default 32, operand/result width.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-low (0 = reset).
REQ-005 mdstartE  input  1  start multiply/divide this cycle.
REQ-006 mdopE  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 srcaE  input  WIDTH  rs operand (multiplicand/dividend).
REQ-008 srcbE  input  WIDTH  rt operand (multiplier/divisor).
REQ-009 hiwriteE  input  1  MTHI: write srcaE to HI.
REQ-010 lowriteE  input  1  MTLO: write srcaE to LO.
REQ-011 hilodisableE  input  2  [1] masks HI write, [0] masks LO write.
REQ-012 hiloselE  input  1  read select: 1 HI, 0 LO.
REQ-013 mdrunE  output  1  unit busy; drives controller stall/disable logic.
REQ-014 hiloE  output  WIDTH  selected HI/LO register contents.

Function
REQ-015 SHALL implement FSM states IDLE, PREP, RUN, FIX; mdrunE = (state != IDLE), registered.
REQ-016 IDLE + mdstartE: capture operands, op, signs; go PREP next cycle.
REQ-017 PREP (1 cycle): signed ops take operand magnitudes; unsigned ops pass through; load 6-bit counter = 0.
REQ-018 RUN (exactly 32 cycles): multiply = radix-2 shift-add on 64-bit accumulator; divide = restoring shift-subtract (one quotient bit/cycle); counter increments, leaves at count 31.
REQ-019 FIX (1 cycle): apply signs, write HI/LO, return IDLE; result visible on hiloE the cycle after FIX.
REQ-020 Total latency: start at cycle T -> mdrunE high T+1..T+34 -> HI/LO updated at end of T+34.
REQ-021 Multiply: {HI,LO} = 64-bit product; signed product negated iff signs differ.
REQ-022 Divide: LO = quotient, HI = remainder; quotient negated iff signs differ; remainder takes dividend sign.
REQ-023 Divide by zero: LO = all ones, HI = dividend as captured (signed ops: original dividend), no exception.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (magnitude arithmetic, wrap).
REQ-025 mdstartE while busy SHALL be ignored (controller stalls; no restart, no corruption).
REQ-026 hiwriteE/lowriteE while IDLE write HI/LO in one cycle unless masked by hilodisableE; ignored while busy.
REQ-027 hiwriteE/lowriteE coincident with mdstartE in IDLE: move-to writes, then operation proceeds; FIX result overwrites.
REQ-028 hiloE is combinational mux of HI/LO; reads while busy return pre-operation values.

Reset
REQ-029 reset=0 at clock edge: state IDLE, mdrunE 0, HI 0, LO 0, counter 0, accumulators 0; hiloE 0.
REQ-030 Reset mid-operation SHALL abort with no HI/LO update; next start behaves as from power-up.

Structure
REQ-031 Shared package md_pkg: mdop encodings (MD_MULT..MD_DIVU), FSM state typedef, WIDTH default, iteration count 32.
REQ-032 One sub-module md_step: combinational single-iteration datapath (add or trial-subtract plus shift); FSM, sign handling and HI/LO stay in muldiv_unit.

Verification
REQ-033 MULTU 7 x 6 -> mdrunE high 34 cycles, then HI=0x00000000, LO=0x0000002A.
REQ-034 MULT -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-035 DIVU 100/7 -> LO=14, HI=2; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-036 DIVU 5/0 -> LO=0xFFFFFFFF, HI=5; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-037 Start MULTU 2x3, reassert mdstartE (DIVU 9/3) at cycle 10 -> ignored, HI=0, LO=6 at T+34.
REQ-038 Start DIVU, reset=0 at cycle 15 -> mdrunE 0, HI=LO=0 next cycle; MTLO 0x1234 with hilodisableE=01 -> LO unchanged; with 00 -> LO=0x1234.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
// Op encodings, FSM states and iteration constants.
package md_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITER  = 32;
    localparam int MD_CNT_W = 6;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } mdop_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PREP = 2'b01,
        S_RUN  = 2'b10,
        S_FIX  = 2'b11
    } md_state_e;

    function automatic logic md_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_step.sv
// One iteration of the multiply/divide datapath.
// Multiply: shift-add. Divide: restoring trial subtract.
module md_step
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    // Single shift-add or shift-subtract step on the accumulator
    always_comb begin
        sum    = '0;
        rem_sh = '0;
        trial  = '0;
        acc_o  = acc_i;
        if (div_i) begin
            // {remainder, quotient} shifted left by one
            rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
            trial  = rem_sh - {1'b0, opnd_i};
            if (trial[WIDTH]) begin
                acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end else begin
                acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end
        end else begin
            // Upper half accumulates, carry shifts into the top bit
            sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
                + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// Start to HI/LO update takes 34 busy cycles.
module muldiv_unit
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mdstartE,
    input  logic [1:0]       mdopE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             hiwriteE,
    input  logic             lowriteE,
    input  logic [1:0]       hilodisableE,
    input  logic             hiloselE,
    output logic             mdrunE,
    output logic [WIDTH-1:0] hiloE
);

    md_state_e state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [WIDTH-1:0]    opnd_q, opnd_d;
    logic [2*WIDTH-1:0]  acc_q, acc_d;
    logic [MD_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0]    lo_q, lo_d;
    logic                mdrun_q, mdrun_d;

    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] step_acc;

    md_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .div_i  (md_is_div(op_q)),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc)
    );

    // Operand signs and magnitudes derived from the captured operands
    always_comb begin
        sa    = md_is_signed(op_q) & a_q[WIDTH-1];
        sb    = md_is_signed(op_q) & b_q[WIDTH-1];
        mag_a = sa ? (~a_q + 1'b1) : a_q;
        mag_b = sb ? (~b_q + 1'b1) : b_q;
        quo   = (sa ^ sb) ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem   = sa ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                   : acc_q[2*WIDTH-1:WIDTH];
        prod  = (sa ^ sb) ? (~acc_q + 1'b1) : acc_q;
    end

    // Next-state logic for the sequencer, datapath and HI/LO
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (hiwriteE && !hilodisableE[1]) hi_d = srcaE;
                if (lowriteE && !hilodisableE[0]) lo_d = srcaE;
                if (mdstartE) begin
                    op_d    = mdopE;
                    a_d     = srcaE;
                    b_d     = srcbE;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                if (md_is_div(op_q)) begin
                    acc_d  = {{WIDTH{1'b0}}, mag_a};
                    opnd_d = mag_b;
                end else begin
                    acc_d  = {{WIDTH{1'b0}}, mag_b};
                    opnd_d = mag_a;
                end
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == MD_CNT_W'(MD_ITER - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (md_is_div(op_q)) begin
                    if (b_q == '0) begin
                        lo_d = '1;
                        hi_d = a_q;
                    end else begin
                        lo_d = quo;
                        hi_d = rem;
                    end
                end else begin
                    {hi_d, lo_d} = prod;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        mdrun_d = (state_d != S_IDLE);
    end

    // State and datapath registers with synchronous clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mdrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mdrun_q <= mdrun_d;
        end
    end

    assign mdrunE = mdrun_q;
    assign hiloE  = hiloselE ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit.
// Inputs change on falling edges; outputs sampled there too.
module tb_muldiv_unit;
    import md_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         mdstartE;
    logic [1:0]   mdopE;
    logic [W-1:0] srcaE;
    logic [W-1:0] srcbE;
    logic         hiwriteE;
    logic         lowriteE;
    logic [1:0]   hilodisableE;
    logic         hiloselE;
    logic         mdrunE;
    logic [W-1:0] hiloE;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        string        name;
    } vec_t;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .mdstartE     (mdstartE),
        .mdopE        (mdopE),
        .srcaE        (srcaE),
        .srcbE        (srcbE),
        .hiwriteE     (hiwriteE),
        .lowriteE     (lowriteE),
        .hilodisableE (hilodisableE),
        .hiloselE     (hiloselE),
        .mdrunE       (mdrunE),
        .hiloE        (hiloE)
    );

    // Issue one op and wait for the unit to go idle (bounded)
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, output int busy);
        @(negedge clk);
        mdopE    = op;
        srcaE    = a;
        srcbE    = b;
        mdstartE = 1'b1;
        @(negedge clk);
        mdstartE = 1'b0;
        srcaE    = '0;
        srcbE    = '0;
        busy = 0;
        while (mdrunE === 1'b1 && busy < 100) begin
            busy++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (mdrunE !== 1'b0) begin
            failures++;
            $display("FAIL reset_run: got %b expected 0", mdrunE);
        end
        hiloselE = 1'b1; #1;
        checks++;
        if (hiloE !== 32'h0) begin
            failures++;
            $display("FAIL reset_hi: got %h expected 0", hiloE);
        end
        hiloselE = 1'b0; #1;
        checks++;
        if (hiloE !== 32'h0) begin
            failures++;
            $display("FAIL reset_lo: got %h expected 0", hiloE);
        end
        reset = 1'b1;
    endtask

    task automatic test_latency;
        int busy;
        run_op(MD_MULTU, 32'd7, 32'd6, busy);
        checks++;
        if (busy != 34) begin
            failures++;
            $display("FAIL latency: got %0d expected 34", busy);
        end
        hiloselE = 1'b1; #1;
        checks++;
        if (hiloE !== 32'h0) begin
            failures++;
            $display("FAIL multu7x6_hi: got %h expected 0", hiloE);
        end
        hiloselE = 1'b0; #1;
        checks++;
        if (hiloE !== 32'h2A) begin
            failures++;
            $display("FAIL multu7x6_lo: got %h expected 2a", hiloE);
        end
    endtask

    task automatic test_arith;
        vec_t v[8];
        int   busy;
        v[0] = '{MD_MULT,  32'hFFFFFFFD, 32'd5,
                 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_m3x5"};
        v[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'hFFFFFFFE, 32'h00000001, "multu_max"};
        v[2] = '{MD_MULT,  32'hFFFFFFF9, 32'hFFFFFFFA,
                 32'h00000000, 32'h0000002A, "mult_negneg"};
        v[3] = '{MD_DIVU,  32'd100, 32'd7,
                 32'd2, 32'd14, "divu_100_7"};
        v[4] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,
                 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2"};
        v[5] = '{MD_DIVU,  32'd5, 32'd0,
                 32'd5, 32'hFFFFFFFF, "divu_by0"};
        v[6] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF,
                 32'h0, 32'h80000000, "div_ovf"};
        v[7] = '{MD_DIV,   32'hFFFFFFF8, 32'd0,
                 32'hFFFFFFF8, 32'hFFFFFFFF, "div_neg_by0"};
        for (int i = 0; i < 8; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, busy);
            hiloselE = 1'b1; #1;
            checks++;
            if (hiloE !== v[i].hi) begin
                failures++;
                $display("FAIL %s_hi: got %h expected %h",
                         v[i].name, hiloE, v[i].hi);
            end
            hiloselE = 1'b0; #1;
            checks++;
            if (hiloE !== v[i].lo) begin
                failures++;
                $display("FAIL %s_lo: got %h expected %h",
                         v[i].name, hiloE, v[i].lo);
            end
        end
    endtask

    task automatic test_move_coincident;
        int busy;
        @(negedge clk);
        mdopE    = MD_MULTU;
        srcaE    = 32'd7;
        srcbE    = 32'd6;
        mdstartE = 1'b1;
        hiwriteE = 1'b1;
        lowriteE = 1'b1;
        @(negedge clk);
        mdstartE = 1'b0;
        srcaE    = 32'h55;
        @(negedge clk);
        hiwriteE = 1'b0;
        lowriteE = 1'b0;
        srcaE    = '0;
        hiloselE = 1'b1; #1;
        checks++;
        if (hiloE !== 32'd7) begin
            failures++;
            $display("FAIL busy_read_hi: got %h expected 7", hiloE);
        end
        hiloselE = 1'b0; #1;
        checks++;
        if (hiloE !== 32'd7) begin
            failures++;
            $display("FAIL busy_read_lo: got %h expected 7", hiloE);
        end
        busy = 0;
        while (mdrunE === 1'b1 && busy < 100) begin
            busy++;
            @(negedge clk);
        end
        hiloselE = 1'b1; #1;
        checks++;
        if (hiloE !== 32'h0) begin
            failures++;
            $display("FAIL coinc_hi: got %h expected 0", hiloE);
        end
        hiloselE = 1'b0; #1;
        checks++;
        if (hiloE !== 32'h2A) begin
            failures++;
            $display("FAIL coinc_lo: got %h expected 2a", hiloE);
        end
    endtask

    task automatic test_busy_ignore;
        int busy;
        @(negedge clk);
        mdopE    = MD_MULTU;
        srcaE    = 32'd2;
        srcbE    = 32'd3;
        mdstartE = 1'b1;
        @(negedge clk);
        mdstartE = 1'b0;
        busy = 0;
        repeat (9) begin
            if (mdrunE === 1'b1) busy++;
            @(negedge clk);
        end
        mdopE    = MD_DIVU;
        srcaE    = 32'd9;
        srcbE    = 32'd3;
        mdstartE = 1'b1;
        if (mdrunE === 1'b1) busy++;
        @(negedge clk);
        mdstartE = 1'b0;
        while (mdrunE === 1'b1 && busy < 100) begin
            busy++;
            @(negedge clk);
        end
        checks++;
        if (busy != 34) begin
            failures++;
            $display("FAIL ignore_busy: got %0d expected 34", busy);
        end
        hiloselE = 1'b1; #1;
        checks++;
        if (hiloE !== 32'h0) begin
            failures++;
            $display("FAIL ignore_hi: got %h expected 0", hiloE);
        end
        hiloselE = 1'b0; #1;
        checks++;
        if (hiloE !== 32'd6) begin
            failures++;
            $display("FAIL ignore_lo: got %h expected 6", hiloE);
        end
        @(negedge clk);
        checks++;
        if (mdrunE !== 1'b0) begin
            failures++;
            $display("FAIL ignore_restart: got %b expected 0", mdrunE);
        end
    endtask

    task automatic test_reset_mid;
        int busy;
        @(negedge clk);
        hiwriteE = 1'b1;
        srcaE    = 32'hBEEF;
        @(negedge clk);
        hiwriteE = 1'b0;
        mdopE    = MD_DIVU;
        srcaE    = 32'd100;
        srcbE    = 32'd7;
        mdstartE = 1'b1;
        @(negedge clk);
        mdstartE = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (mdrunE !== 1'b0) begin
            failures++;
            $display("FAIL abort_run: got %b expected 0", mdrunE);
        end
        hiloselE = 1'b1; #1;
        checks++;
        if (hiloE !== 32'h0) begin
            failures++;
            $display("FAIL abort_hi: got %h expected 0", hiloE);
        end
        hiloselE = 1'b0; #1;
        checks++;
        if (hiloE !== 32'h0) begin
            failures++;
            $display("FAIL abort_lo: got %h expected 0", hiloE);
        end
        @(negedge clk);
        lowriteE     = 1'b1;
        srcaE        = 32'h1234;
        hilodisableE = 2'b01;
        @(negedge clk);
        lowriteE = 1'b0;
        #1;
        checks++;
        if (hiloE !== 32'h0) begin
            failures++;
            $display("FAIL mtlo_masked: got %h expected 0", hiloE);
        end
        hilodisableE = 2'b00;
        lowriteE     = 1'b1;
        @(negedge clk);
        lowriteE = 1'b0;
        srcaE    = '0;
        #1;
        checks++;
        if (hiloE !== 32'h1234) begin
            failures++;
            $display("FAIL mtlo: got %h expected 1234", hiloE);
        end
        run_op(MD_MULTU, 32'd7, 32'd6, busy);
        checks++;
        if (busy != 34) begin
            failures++;
            $display("FAIL post_reset_busy: got %0d expected 34", busy);
        end
        hiloselE = 1'b0; #1;
        checks++;
        if (hiloE !== 32'h2A) begin
            failures++;
            $display("FAIL post_reset_lo: got %h expected 2a", hiloE);
        end
    endtask

    initial begin
        reset        = 1'b0;
        mdstartE     = 1'b0;
        mdopE        = 2'b00;
        srcaE        = '0;
        srcbE        = '0;
        hiwriteE     = 1'b0;
        lowriteE     = 1'b0;
        hilodisableE = 2'b00;
        hiloselE     = 1'b0;
        test_reset();
        test_latency();
        test_arith();
        test_move_coincident();
        test_busy_ignore();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
